if_id_stage: RTL and testbench

IF/ID pipeline stage of the five-stage RISC-V core: captures the fetched PC and instruction and presents them to decode. It feeds the ID/EX register. It contains the load-use hazard detector, which stalls fetch and requests a bubble into ID/EX. It flushes on a taken branch and keeps saturating stall and flush counters for performance debug.

---
 rtl/if_id_stage.sv | 130 +++++++++++++
 tb/tb_if_id_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the five-stage RISC-V core.
// Holds the fetched PC/instruction for decode and detects load-use hazards
// against ID/EX. On a hazard it stalls fetch and asks for a bubble in ID/EX.
// On a taken branch it flushes the slot. It also keeps saturating
// stall/flush event counters for performance debug.
// All state changes on the falling edge of clk, matching the other pipeline registers.
module if_id_stage #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [INST_W-1:0] Instruction_in,
  input  logic              Branch_Taken,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_RD,
  output logic [PC_W-1:0]   PC_out,
  output logic [INST_W-1:0] Instruction_out,
  output logic              Valid_out,
  output logic [4:0]        RS1,
  output logic [4:0]        RS2,
  output logic              PC_Write,
  output logic              Bubble,
  output logic [1:0]        State,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  // ADDI x0, x0, 0: the canonical NOP loaded on reset and on flush.
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic       use_rs1, use_rs2;
  logic       hazard;
  logic       do_flush, do_stall;

  assign opcode = Instruction_out[6:0];
  assign RS1    = Instruction_out[19:15];
  assign RS2    = Instruction_out[24:20];
  assign State  = state_q;

  // Decode which source fields the held instruction actually reads.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I_ALU, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard: the load in ID/EX writes a register the held instruction reads.
  // A flushed slot (Valid_out=0) and a load into x0 never stall.
  always_comb begin
    hazard = Valid_out && ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
             ((use_rs1 && (ID_EX_RD == RS1)) || (use_rs2 && (ID_EX_RD == RS2)));
  end

  // FSM state register.
  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // FSM next state: flush beats stall, otherwise return to RUN.
  always_comb begin
    state_d = ST_RUN;
    if (Branch_Taken) state_d = ST_FLUSH;
    else if (hazard)  state_d = ST_STALL;
  end

  // FSM outputs: fetch/decode control and the per-edge action select.
  always_comb begin
    PC_Write = ~hazard | Branch_Taken;
    Bubble   = hazard | ~Valid_out;
    do_flush = Branch_Taken;
    do_stall = ~Branch_Taken & hazard;
  end

  // Pipeline register: flush, hold on stall, or capture the fetched instruction.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      PC_out          <= '0;
      Instruction_out <= NOP_INST;
      Valid_out       <= 1'b0;
    end else if (do_flush) begin
      PC_out          <= PC_in;
      Instruction_out <= NOP_INST;
      Valid_out       <= 1'b0;
    end else if (!do_stall) begin
      PC_out          <= PC_in;
      Instruction_out <= Instruction_in;
      Valid_out       <= 1'b1;
    end
  end

  // Saturating event counters; only reset clears them.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (do_stall && (Stall_Count != '1)) Stall_Count <= Stall_Count + 1'b1;
      if (do_flush && (Flush_Count != '1)) Flush_Count <= Flush_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, streaming, load-use stalls,
// x0/LUI/store/I-type hazard cases, flush priority, counter saturation
// and reset in the middle of a stall.
module tb_if_id_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_A   = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI_B   = 32'h0012_8313; // addi x6,x5,1
  localparam logic [31:0] ADDI_C   = 32'h0054_0313; // addi x6,x8,5 (rs2 field = 5, unused)
  localparam logic [31:0] ADD_X5X7 = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] LUI_X6   = 32'h0002_8337; // lui  x6 (bits 19:15 = 5, unused)
  localparam logic [31:0] SW_X5    = 32'h0054_2023; // sw   x5,0(x8)

  logic        clk = 1'b1;
  logic        reset_n = 1'b0;
  logic [63:0] PC_in = '0;
  logic [31:0] Instruction_in = NOP;
  logic        Branch_Taken = 1'b0;
  logic        ID_EX_MemRead = 1'b0;
  logic [4:0]  ID_EX_RD = '0;

  logic [63:0] PC_out;
  logic [31:0] Instruction_out;
  logic        Valid_out, PC_Write, Bubble;
  logic [4:0]  RS1, RS2;
  logic [1:0]  State;
  logic [31:0] Stall_Count, Flush_Count;

  logic [63:0] s_pc;
  logic [31:0] s_inst;
  logic        s_valid, s_pcw, s_bubble;
  logic [4:0]  s_rs1, s_rs2;
  logic [1:0]  s_state;
  logic [3:0]  s_stall, s_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .reset_n(reset_n), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .Branch_Taken(Branch_Taken), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RD(ID_EX_RD),
    .PC_out(PC_out), .Instruction_out(Instruction_out), .Valid_out(Valid_out),
    .RS1(RS1), .RS2(RS2), .PC_Write(PC_Write), .Bubble(Bubble), .State(State),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  if_id_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .Branch_Taken(Branch_Taken), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RD(ID_EX_RD),
    .PC_out(s_pc), .Instruction_out(s_inst), .Valid_out(s_valid),
    .RS1(s_rs1), .RS2(s_rs2), .PC_Write(s_pcw), .Bubble(s_bubble), .State(s_state),
    .Stall_Count(s_stall), .Flush_Count(s_flush)
  );

  // Advance one active (falling) edge and settle before sampling.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (PC_out !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC_out, 64'h0); end
    checks++; if (Instruction_out !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", Instruction_out, NOP); end
    checks++; if (Valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Valid_out); end
    checks++; if (State !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", State); end
    checks++; if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", Stall_Count, Flush_Count); end
    checks++; if (Bubble !== 1'b1 || PC_Write !== 1'b1) begin errors++; $display("FAIL reset_ctrl got bubble=%b pcw=%b want 1/1", Bubble, PC_Write); end
  endtask

  task automatic test_stream();
    logic [63:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{64'h0, 64'h4, 64'h8};
    ins = '{ADDI_A, ADDI_B, ADDI_C};
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PC_in = pcs[i];
      Instruction_in = ins[i];
      tick();
      checks++; if (PC_out !== pcs[i] || Instruction_out !== ins[i]) begin errors++; $display("FAIL stream_%0d got %h/%h want %h/%h", i, PC_out, Instruction_out, pcs[i], ins[i]); end
      checks++; if (Valid_out !== 1'b1 || State !== 2'b00) begin errors++; $display("FAIL stream_ctl_%0d got valid=%b state=%b want 1/00", i, Valid_out, State); end
    end
    checks++; if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin errors++; $display("FAIL stream_counts got %0d/%0d want 0/0", Stall_Count, Flush_Count); end
    checks++; if (RS1 !== 5'd8 || RS2 !== 5'd5) begin errors++; $display("FAIL stream_rs got %0d/%0d want 8/5", RS1, RS2); end
  endtask

  task automatic test_load_use();
    PC_in = 64'hC; Instruction_in = ADD_X5X7;
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd5;
    PC_in = 64'h10; Instruction_in = ADDI_A;
    #1;
    checks++; if (PC_Write !== 1'b0 || Bubble !== 1'b1) begin errors++; $display("FAIL lu_ctrl got pcw=%b bubble=%b want 0/1", PC_Write, Bubble); end
    tick();
    checks++; if (PC_out !== 64'hC || Instruction_out !== ADD_X5X7) begin errors++; $display("FAIL lu_hold got %h/%h want c/%h", PC_out, Instruction_out, ADD_X5X7); end
    checks++; if (State !== 2'b01 || Stall_Count !== 32'd1) begin errors++; $display("FAIL lu_stall got state=%b cnt=%0d want 01/1", State, Stall_Count); end
    ID_EX_MemRead = 1'b0;
    #1;
    checks++; if (PC_Write !== 1'b1 || Bubble !== 1'b0) begin errors++; $display("FAIL lu_clear got pcw=%b bubble=%b want 1/0", PC_Write, Bubble); end
    tick();
    checks++; if (PC_out !== 64'h10 || State !== 2'b00) begin errors++; $display("FAIL lu_advance got pc=%h state=%b want 10/00", PC_out, State); end
  endtask

  task automatic test_no_stall();
    PC_in = 64'h14; Instruction_in = ADD_X5X7;
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd0;
    PC_in = 64'h18; Instruction_in = LUI_X6;
    #1;
    checks++; if (PC_Write !== 1'b1) begin errors++; $display("FAIL x0_pcw got %b want 1", PC_Write); end
    tick();
    checks++; if (PC_out !== 64'h18 || State !== 2'b00 || Stall_Count !== 32'd1) begin errors++; $display("FAIL x0_adv got pc=%h state=%b cnt=%0d want 18/00/1", PC_out, State, Stall_Count); end
    ID_EX_RD = 5'd5;
    PC_in = 64'h1C; Instruction_in = SW_X5;
    #1;
    checks++; if (PC_Write !== 1'b1 || Bubble !== 1'b0) begin errors++; $display("FAIL lui_ctrl got pcw=%b bubble=%b want 1/0", PC_Write, Bubble); end
    tick();
    checks++; if (PC_out !== 64'h1C || State !== 2'b00) begin errors++; $display("FAIL lui_adv got pc=%h state=%b want 1c/00", PC_out, State); end
  endtask

  task automatic test_store();
    PC_in = 64'h20; Instruction_in = ADDI_C;
    #1;
    checks++; if (PC_Write !== 1'b0) begin errors++; $display("FAIL sw_pcw got %b want 0", PC_Write); end
    tick();
    checks++; if (PC_out !== 64'h1C || State !== 2'b01 || Stall_Count !== 32'd2) begin errors++; $display("FAIL sw_stall got pc=%h state=%b cnt=%0d want 1c/01/2", PC_out, State, Stall_Count); end
    ID_EX_MemRead = 1'b0;
    tick();
    ID_EX_MemRead = 1'b1;
    PC_in = 64'h24; Instruction_in = ADD_X5X7;
    #1;
    checks++; if (PC_Write !== 1'b1) begin errors++; $display("FAIL itype_pcw got %b want 1", PC_Write); end
    tick();
    checks++; if (PC_out !== 64'h24 || State !== 2'b00 || Stall_Count !== 32'd2) begin errors++; $display("FAIL itype_adv got pc=%h state=%b cnt=%0d want 24/00/2", PC_out, State, Stall_Count); end
  endtask

  task automatic test_flush();
    Branch_Taken = 1'b1;
    PC_in = 64'h28; Instruction_in = ADDI_B;
    #1;
    checks++; if (PC_Write !== 1'b1 || Bubble !== 1'b1) begin errors++; $display("FAIL fl_ctrl got pcw=%b bubble=%b want 1/1", PC_Write, Bubble); end
    tick();
    checks++; if (Instruction_out !== NOP || Valid_out !== 1'b0 || PC_out !== 64'h28) begin errors++; $display("FAIL fl_regs got %h/%b/%h want %h/0/28", Instruction_out, Valid_out, PC_out, NOP); end
    checks++; if (State !== 2'b10 || Flush_Count !== 32'd1 || Stall_Count !== 32'd2) begin errors++; $display("FAIL fl_cnt got state=%b fl=%0d st=%0d want 10/1/2", State, Flush_Count, Stall_Count); end
    Branch_Taken = 1'b0;
    PC_in = 64'h2C; Instruction_in = ADDI_A;
    #1;
    checks++; if (PC_Write !== 1'b1 || Bubble !== 1'b1) begin errors++; $display("FAIL fl_slot got pcw=%b bubble=%b want 1/1", PC_Write, Bubble); end
    tick();
    checks++; if (PC_out !== 64'h2C || Valid_out !== 1'b1 || State !== 2'b00) begin errors++; $display("FAIL fl_next got pc=%h valid=%b state=%b want 2c/1/00", PC_out, Valid_out, State); end
  endtask

  task automatic test_saturation_and_reset();
    ID_EX_MemRead = 1'b0;
    PC_in = 64'h8000_0000_0000_0030; Instruction_in = ADD_X5X7;
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd5;
    PC_in = 64'h34; Instruction_in = ADDI_A;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (s_stall !== 4'hF) begin errors++; $display("FAIL sat_stall got %h want f", s_stall); end
    checks++; if (Stall_Count !== 32'd22) begin errors++; $display("FAIL wide_stall got %0d want 22", Stall_Count); end
    checks++; if (s_flush !== 4'h1) begin errors++; $display("FAIL sat_flush got %h want 1", s_flush); end
    checks++; if (PC_out !== 64'h8000_0000_0000_0030 || State !== 2'b01) begin errors++; $display("FAIL sat_hold got pc=%h state=%b want 8000000000000030/01", PC_out, State); end
    reset_n = 1'b0;
    tick();
    checks++; if (PC_out !== 64'h0 || Instruction_out !== NOP || Valid_out !== 1'b0 || State !== 2'b00) begin errors++; $display("FAIL midrst_regs got %h/%h/%b/%b want 0/%h/0/00", PC_out, Instruction_out, Valid_out, State, NOP); end
    checks++; if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0 || s_stall !== 4'h0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d/%0d want 0/0/0", Stall_Count, Flush_Count, s_stall); end
    checks++; if (Bubble !== 1'b1 || PC_Write !== 1'b1) begin errors++; $display("FAIL midrst_ctrl got bubble=%b pcw=%b want 1/1", Bubble, PC_Write); end
    reset_n = 1'b1;
    ID_EX_MemRead = 1'b0;
    PC_in = 64'h40; Instruction_in = ADDI_B;
    tick();
    checks++; if (PC_out !== 64'h40 || Instruction_out !== ADDI_B || Valid_out !== 1'b1) begin errors++; $display("FAIL post_rst got %h/%h/%b want 40/%h/1", PC_out, Instruction_out, Valid_out, ADDI_B); end
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_load_use();
    test_no_stall();
    test_store();
    test_flush();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
